// File: rtl/serial_subtractor_pkg.sv
// rtl/serial_subtractor_pkg.sv - shared FSM state type and sizing helper for the serial subtractor
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic int clog2(input int value);
    int r;
    int x;
    r = 0;
    x = value - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - single-bit combinational full-subtractor cell
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial a - b - bin, LSB first, through one full-subtractor cell
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int CW = clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d, diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             brw_q, brw_d, bout_q, bout_d, msb_q, msb_d;
  logic             rdy_q, rdy_d, vld_q, vld_d;
  logic             cell_d, cell_b;
  logic             accept;

  full_subtractor u_cell (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .bin  (brw_q),
    .d    (cell_d),
    .bout (cell_b)
  );

  // rdy_q stays low through reset and the first edge after it, so accept needs both
  assign accept = (state_q == IDLE) && rdy_q && in_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SHIFT;
      SHIFT:   if (cnt_q == LAST) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    a_sh_d = a_sh_q;
    b_sh_d = b_sh_q;
    diff_d = diff_q;
    cnt_d  = cnt_q;
    brw_d  = brw_q;
    bout_d = bout_q;
    msb_d  = msb_q;
    rdy_d  = (state_d == IDLE);
    vld_d  = (state_d == DONE);
    case (state_q)
      IDLE: begin
        if (accept) begin
          a_sh_d = a;
          b_sh_d = b;
          cnt_d  = '0;
          brw_d  = bin;
          bout_d = 1'b0;
          msb_d  = 1'b0;
        end
      end
      SHIFT: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        diff_d = {cell_d, diff_q[WIDTH-1:1]};
        brw_d  = cell_b;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          msb_d  = brw_q;
          bout_d = cell_b;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_q <= '0;
      b_sh_q <= '0;
      diff_q <= '0;
      cnt_q  <= '0;
      brw_q  <= 1'b0;
      bout_q <= 1'b0;
      msb_q  <= 1'b0;
      rdy_q  <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      a_sh_q <= a_sh_d;
      b_sh_q <= b_sh_d;
      diff_q <= diff_d;
      cnt_q  <= cnt_d;
      brw_q  <= brw_d;
      bout_q <= bout_d;
      msb_q  <= msb_d;
      rdy_q  <= rdy_d;
      vld_q  <= vld_d;
    end
  end

  assign in_ready  = rdy_q;
  assign out_valid = vld_q;
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign ovf       = msb_q ^ bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor against an arithmetic model
module tb_serial_subtractor;

  localparam int W = 4;

  typedef struct packed {
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
  } res_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] diff;
  logic         bout;
  logic         ovf;

  int   checks = 0;
  int   errors = 0;
  int   results = 0;
  int   exp_results = 0;
  logic prev_ov = 1'b0;
  res_t exp_r = '0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  // Integer arithmetic: unsigned difference for diff/bout, signed range test for ovf
  function automatic res_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbi);
    res_t r;
    int ud, sa, sb, sd;
    ud = int'(ma) - int'(mb) - int'(mbi);
    sa = ma[W-1] ? int'(ma) - (1 << W) : int'(ma);
    sb = mb[W-1] ? int'(mb) - (1 << W) : int'(mb);
    sd = sa - sb - int'(mbi);
    r.diff = W'(ud);
    r.bout = (ud < 0);
    r.ovf  = (sd < -(1 << (W - 1))) || (sd > (1 << (W - 1)) - 1);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst_n && in_valid && in_ready) exp_r <= model(a, b, bin);
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        check("mon_diff", 32'(diff), 32'(exp_r.diff));
        check("mon_bout", 32'(bout), 32'(exp_r.bout));
        check("mon_ovf", 32'(ovf), 32'(exp_r.ovf));
        check("mon_ready_in_done", 32'(in_ready), 32'd0);
        if (!prev_ov) results++;
      end
      prev_ov = out_valid;
    end else begin
      prev_ov = 1'b0;
    end
  end

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbi,
                        input logic [W-1:0] ed, input logic eb, input logic eo,
                        input int hold, input bit pulse);
    int n;
    int lat;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("idle_ready", 32'(in_ready), 32'd1);
    a = ta; b = tb; bin = tbi; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      if (pulse && lat == 1) begin
        in_valid = 1'b1; a = 4'b1111; b = 4'b0000; bin = 1'b0;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    check("latency", 32'(lat), 32'(W));
    check("lit_diff", 32'(diff), 32'(ed));
    check("lit_bout", 32'(bout), 32'(eb));
    check("lit_ovf", 32'(ovf), 32'(eo));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_ready", 32'(in_ready), 32'd0);
      check("hold_diff", 32'(diff), 32'(ed));
      check("hold_bout", 32'(bout), 32'(eb));
      check("hold_ovf", 32'(ovf), 32'(eo));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("release_valid", 32'(out_valid), 32'd0);
    check("release_ready", 32'(in_ready), 32'd1);
    exp_results++;
  endtask

  initial begin
    res_t r;
    logic [W-1:0] ra, rb;
    logic rbi;
    #3;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_bout", 32'(bout), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(in_ready), 32'd1);

    // 11-6-1=4 unsigned; signed -5-6-1=-12 is out of range, so ovf is set
    run_op(4'b1011, 4'b0110, 1'b1, 4'b0100, 1'b0, 1'b1, 0, 1'b0);
    run_op(4'b0010, 4'b1111, 1'b0, 4'b0011, 1'b1, 1'b0, 0, 1'b0);
    run_op(4'b0111, 4'b1000, 1'b0, 4'b1111, 1'b1, 1'b1, 0, 1'b0);
    run_op(4'b1000, 4'b0001, 1'b0, 4'b0111, 1'b0, 1'b1, 0, 1'b0);
    run_op(4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b1, 1'b0, 5, 1'b0);
    run_op(4'b0101, 4'b0011, 1'b0, 4'b0010, 1'b0, 1'b0, 0, 1'b1);
    repeat (8) @(negedge clk);
    check("busy_no_extra_result", 32'(results), 32'(exp_results));

    for (int i = 0; i < 6; i++) begin
      ra = W'($urandom_range(0, 15));
      rb = W'($urandom_range(0, 15));
      rbi = 1'($urandom_range(0, 1));
      r = model(ra, rb, rbi);
      run_op(ra, rb, rbi, r.diff, r.bout, r.ovf, 0, 1'b0);
    end

    // Abort an operation in its second SHIFT cycle
    a = 4'b1110; b = 4'b0001; bin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_diff", 32'(diff), 32'd0);
    check("mid_rst_bout", 32'(bout), 32'd0);
    check("mid_rst_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_ready_after", 32'(in_ready), 32'd1);
    run_op(4'b0001, 4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0, 0, 1'b0);
    repeat (4) @(negedge clk);
    check("result_count", 32'(results), 32'(exp_results));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
